// File: rtl/dff_result_scanout.sv
// Capture-and-scan-out stage: snapshots the DFF array result vector on start
// and streams it LSB-word-first over a valid/ready handshake.
module dff_result_scanout #(
    parameter int unsigned WIDTH = 88,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             sr,
    input  logic [WIDTH-1:0] q,
    input  logic             start,
    output logic             busy,
    output logic [CHUNK-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             dout_last,
    output logic             changed,
    output logic [15:0]      capture_count
);

    localparam int unsigned NW = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int unsigned PW = NW * CHUNK;
    localparam int unsigned IW = (NW > 1) ? $clog2(NW) : 1;
    localparam int unsigned CW = 16;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    idx_nx;
    logic [IW-1:0]    idx_inc;
    logic             busy_nx;
    logic             valid_nx;
    logic             last_nx;
    logic [CHUNK-1:0] dout_nx;
    logic             accept;
    logic             final_word;
    logic [WIDTH-1:0] snap;
    logic [PW-1:0]    snap_pad;
    logic             first;

    // Zero-padded view so the last word reads 0 above WIDTH-1
    assign snap_pad   = PW'(snap);
    assign idx_inc    = idx + IW'(1);
    assign final_word = (idx == IW'(NW - 1));

    // Next-state and next registered-output values
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        busy_nx  = busy;
        valid_nx = dout_valid;
        last_nx  = dout_last;
        dout_nx  = dout;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = SEND;
                    idx_nx   = '0;
                    busy_nx  = 1'b1;
                    valid_nx = 1'b1;
                    last_nx  = (NW == 1);
                    dout_nx  = CHUNK'(PW'(q));
                end
            end
            SEND: begin
                // dout_valid is always high here, so ready alone is the handshake
                if (dout_ready) begin
                    if (final_word) begin
                        state_nx = IDLE;
                        busy_nx  = 1'b0;
                        valid_nx = 1'b0;
                        last_nx  = 1'b0;
                        dout_nx  = '0;
                    end else begin
                        idx_nx  = idx_inc;
                        last_nx = (idx_inc == IW'(NW - 1));
                        dout_nx = CHUNK'(snap_pad >> (32'(idx_inc) * CHUNK));
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and handshake output registers
    always_ff @(posedge clk) begin
        if (sr) begin
            state      <= IDLE;
            idx        <= '0;
            busy       <= 1'b0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            dout       <= '0;
        end else begin
            state      <= state_nx;
            idx        <= idx_nx;
            busy       <= busy_nx;
            dout_valid <= valid_nx;
            dout_last  <= last_nx;
            dout       <= dout_nx;
        end
    end

    // Snapshot, change flag and capture counter; touched only on accepted start
    always_ff @(posedge clk) begin
        if (sr) begin
            snap          <= '0;
            first         <= 1'b1;
            changed       <= 1'b0;
            capture_count <= '0;
        end else if (accept) begin
            snap          <= q;
            first         <= 1'b0;
            changed       <= first | (q != snap);
            capture_count <= capture_count + CW'(1);
        end
    end

endmodule

// File: tb/tb_dff_result_scanout.sv
// Scoreboard bench for dff_result_scanout: stimulus pushes expected words,
// a negedge monitor pops and compares on every handshake.
module tb_dff_result_scanout;

    localparam int unsigned WIDTH = 88;
    localparam int unsigned CHUNK = 8;
    localparam int unsigned NW    = 11;

    logic             clk = 1'b0;
    logic             sr = 1'b1;
    logic             start = 1'b0;
    logic             dout_ready = 1'b0;
    logic [WIDTH-1:0] q = '0;
    logic             busy;
    logic [CHUNK-1:0] dout;
    logic             dout_valid;
    logic             dout_last;
    logic             changed;
    logic [15:0]      capture_count;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0]  w;
        logic        last;
        logic        chg;
        logic [15:0] cnt;
    } exp_t;

    exp_t             exp_q[$];
    exp_t             e;
    logic [WIDTH-1:0] m_snap;
    logic             m_first;
    logic             m_changed;
    logic [15:0]      m_count;

    always #5 clk = ~clk;

    dff_result_scanout #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk          (clk),
        .sr           (sr),
        .q            (q),
        .start        (start),
        .busy         (busy),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .dout_last    (dout_last),
        .changed      (changed),
        .capture_count(capture_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_snap    = '0;
        m_first   = 1'b1;
        m_changed = 1'b0;
        m_count   = '0;
        exp_q.delete();
    endtask

    // Reference: a capture yields NW byte slices of the vector, LSB first
    task automatic model_capture(input logic [WIDTH-1:0] qv);
        m_changed = m_first || (qv != m_snap);
        m_first   = 1'b0;
        m_snap    = qv;
        m_count   = m_count + 16'd1;
        for (int k = 0; k < NW; k++) begin
            exp_t             x;
            logic [WIDTH-1:0] t;
            t      = qv >> (k * CHUNK);
            x.w    = t[7:0];
            x.last = (k == NW - 1);
            x.chg  = m_changed;
            x.cnt  = m_count;
            exp_q.push_back(x);
        end
    endtask

    // mode: 0 ready held high, 1 ready pattern 1,0,0, 2 random ready
    task automatic frame(input logic [WIDTH-1:0] qv, input int mode, input bit ign, input int rst_at);
        int i;
        q          = qv;
        start      = 1'b1;
        dout_ready = (mode == 0);
        step();
        start = 1'b0;
        model_capture(qv);
        q = WIDTH'({$urandom(), $urandom(), $urandom()});
        i = 0;
        while (exp_q.size() != 0) begin
            if (i >= 400) begin
                n_assert++;
                n_fail++;
                $display("FAIL frame_timeout: got %0d words left, required 0", exp_q.size());
                exp_q.delete();
                break;
            end
            if (i == rst_at) begin
                sr = 1'b1;
                step();
                sr = 1'b0;
                model_reset();
                break;
            end
            case (mode)
                0:       dout_ready = 1'b1;
                1:       dout_ready = (i % 3 == 0);
                default: dout_ready = 1'($urandom_range(0, 1));
            endcase
            start = ign && (i == 3 || i == 10);
            step();
            i++;
        end
        start = 1'b0;
    endtask

    // Monitor: checks status every cycle and words on every handshake
    always @(negedge clk) begin
        if (!sr) begin
            chk("busy", 32'(busy), 32'(exp_q.size() != 0));
            chk("dout_valid", 32'(dout_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                if (dout_valid) begin
                    e = exp_q[0];
                    chk("dout", 32'(dout), 32'(e.w));
                    chk("dout_last", 32'(dout_last), 32'(e.last));
                    chk("changed", 32'(changed), 32'(e.chg));
                    chk("capture_count", 32'(capture_count), 32'(e.cnt));
                    if (dout_ready) void'(exp_q.pop_front());
                end
            end else begin
                chk("idle_changed", 32'(changed), 32'(m_changed));
                chk("idle_count", 32'(capture_count), 32'(m_count));
                chk("idle_last", 32'(dout_last), 32'h0);
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] base;
        logic [WIDTH-1:0] rq;
        model_reset();
        base = 88'h0123456789ABCDEF012345;

        sr = 1'b1;
        step();
        step();
        chk("reset_dout", 32'(dout), 32'h0);
        sr = 1'b0;
        repeat (20) step();

        frame(base, 0, 1'b0, -1);
        frame(base, 1, 1'b0, -1);
        frame(base ^ (88'd1 << 87), 0, 1'b1, -1);

        rq = WIDTH'({$urandom(), $urandom(), $urandom()});
        for (int n = 0; n < 6; n++) begin
            if (n % 3 != 1) rq = WIDTH'({$urandom(), $urandom(), $urandom()});
            frame(rq, 2, 1'b0, -1);
            repeat ($urandom_range(0, 3)) step();
        end

        frame(base, 0, 1'b0, 5);
        frame(base, 0, 1'b0, -1);

        // Preload the counter near wrap rather than running 65536 frames
        m_count = 16'hFFFD;
        force dut.capture_count = 16'hFFFD;
        step();
        release dut.capture_count;
        step();
        frame(base, 0, 1'b0, -1);
        frame(base, 0, 1'b0, -1);
        frame(~base, 0, 1'b0, -1);
        step();
        step();
        chk("wrap_count", 32'(capture_count), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
